resdata_reader: RTL and testbench

// Read-side drain engine for the result-data FIFO. On a start pulse it pops exactly job_len words from the

---
 rtl/definitions_pkg.sv | 14 +
 rtl/resdata_skid_buf.sv | 59 +++++
 rtl/resdata_reader.sv | 100 ++++++++++
 tb/tb_resdata_reader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definitions_pkg.sv
// Shared sizing constants for the compute array and the result-data reader state type.
package definitions_pkg;

  localparam int COMPUTING_GROUP_SIZE       = 4;
  localparam int FEATURE_BIT_SIZE           = 8;
  localparam int COMPUTING_UNIT_OUTPUT_SIZE = 4;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_RUN,
    RD_DONE
  } resrd_state_t;

endpackage

// File: rtl/resdata_skid_buf.sv
// Two-entry circular buffer between the FIFO read port and the output stream.
// The head word is presented combinationally so a filled entry is visible without a bubble.
module resdata_skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] occ_reg;
  logic [1:0] occ_next;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] data_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_reg <= '0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= push_data;
        end
      end
    end
  endgenerate

  // Push and pop in the same cycle leave occupancy unchanged while both pointers move.
  always_comb begin
    occ_next = occ_reg;
    if (push && !pop) begin
      occ_next = occ_reg + 2'd1;
    end else if (pop && !push) begin
      occ_next = occ_reg - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      occ_reg    <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      occ_reg <= occ_next;
    end
  end

  assign occ  = occ_reg;
  assign head = rd_ptr_reg ? g_entry[1].data_reg : g_entry[0].data_reg;

endmodule

// File: rtl/resdata_reader.sv
// Drains exactly job_len words from the result FIFO into a valid/ready stream with last on the
// final word; FIFO reads are credit-limited so the two-entry skid buffer can never overflow.
module resdata_reader
  import definitions_pkg::*;
#(
  parameter int DATA_WIDTH = COMPUTING_GROUP_SIZE * FEATURE_BIT_SIZE,
  parameter int MEM_DEPTH  = 48 * COMPUTING_UNIT_OUTPUT_SIZE,
  parameter int LEN_WIDTH  = $clog2(MEM_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  job_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  resrd_state_t          state_reg;
  resrd_state_t          state_next;
  logic [LEN_WIDTH-1:0]  len_reg;
  logic [LEN_WIDTH-1:0]  issue_cnt_reg;
  logic [LEN_WIDTH-1:0]  out_cnt_reg;
  logic                  inflight_reg;
  logic [1:0]            skid_occ;
  logic [DATA_WIDTH-1:0] skid_head;
  logic                  handshake;
  logic                  credit_ok;

  // A read in flight has already claimed a skid slot, so it counts against the credit.
  assign credit_ok  = ({1'b0, skid_occ} + {2'b00, inflight_reg}) < 3'd2;
  assign fifo_rd_en = (state_reg == RD_RUN) && !fifo_empty &&
                      (issue_cnt_reg < len_reg) && credit_ok;

  assign m_valid   = (skid_occ != 2'd0);
  assign m_data    = skid_head;
  assign handshake = m_valid && m_ready;
  assign m_last    = m_valid && (out_cnt_reg == (len_reg - LEN_WIDTH'(1)));

  assign busy = (state_reg == RD_RUN);
  assign done = (state_reg == RD_DONE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RD_IDLE: begin
        if (start) begin
          state_next = (job_len == '0) ? RD_DONE : RD_RUN;
        end
      end
      RD_RUN: begin
        if ((out_cnt_reg == len_reg) && (skid_occ == 2'd0)) begin
          state_next = RD_DONE;
        end
      end
      RD_DONE: state_next = RD_IDLE;
      default: state_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RD_IDLE;
      len_reg       <= '0;
      issue_cnt_reg <= '0;
      out_cnt_reg   <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= fifo_rd_en;
      if ((state_reg == RD_IDLE) && start) begin
        len_reg       <= job_len;
        issue_cnt_reg <= '0;
        out_cnt_reg   <= '0;
      end else begin
        if (fifo_rd_en) issue_cnt_reg <= issue_cnt_reg + LEN_WIDTH'(1);
        if (handshake)  out_cnt_reg   <= out_cnt_reg + LEN_WIDTH'(1);
      end
    end
  end

  resdata_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (fifo_dout),
    .pop       (handshake),
    .occ       (skid_occ),
    .head      (skid_head)
  );

endmodule

// File: tb/tb_resdata_reader.sv
// Scoreboard bench for resdata_reader: a queue-based FIFO model feeds the DUT, expected beats are
// queued at job start and a monitor thread compares every output handshake.
module tb_resdata_reader;
  import definitions_pkg::*;

  localparam int DW = COMPUTING_GROUP_SIZE * FEATURE_BIT_SIZE;
  localparam int LW = $clog2(48 * COMPUTING_UNIT_OUTPUT_SIZE) + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] job_len = '0;
  logic          busy, done;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_dout = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;

  logic          push_en = 1'b0;
  logic [DW-1:0] push_word = '0;
  logic          fifo_clear = 1'b0;
  logic [DW-1:0] fifo_q[$];
  int            pops = 0;

  exp_t          exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            done_cnt = 0;
  int            rdy_mode = 0;

  always #5 clk = ~clk;

  resdata_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .job_len    (job_len),
    .busy       (busy),
    .done       (done),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  // FIFO model: one-cycle read latency, registered empty flag.
  always @(posedge clk) begin
    if (fifo_clear) begin
      fifo_q.delete();
    end else begin
      if (fifo_rd_en && fifo_q.size() > 0) begin
        fifo_dout <= fifo_q.pop_front();
        pops <= pops + 1;
      end
      if (push_en) fifo_q.push_back(push_word);
    end
    fifo_empty <= (fifo_clear || fifo_q.size() == 0);
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      push_en = 1'b1;
      push_word = base + DW'(i);
      tick();
    end
    push_en = 1'b0;
  endtask

  task automatic flush_fifo();
    fifo_clear = 1'b1;
    tick();
    fifo_clear = 1'b0;
    tick();
  endtask

  task automatic run_job(input int len, input logic [DW-1:0] first);
    for (int i = 0; i < len; i++) exp_q.push_back('{d: first + DW'(i), l: (i == len - 1)});
    job_len = LW'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    $display("job len=%0d first=0x%0h started", len, first);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(done == 1'b1, {name, "_done_seen"}, 32'(done), 1);
    chk(exp_q.size() == 0, {name, "_beats_left"}, 32'(exp_q.size()), 0);
    tick();
    chk(done == 1'b0, {name, "_done_pulse"}, 32'(done), 0);
    chk(busy == 1'b0, {name, "_busy_after"}, 32'(busy), 0);
    $display("job %s finished after %0d cycles", name, n);
  endtask

  initial begin
    int base;
    fork
      // Backpressure driver: mode 0 never ready, 1 always ready, 2 pattern 1,0,0.
      begin : rdy_drv
        int ph = 0;
        forever begin
          @(posedge clk);
          #1;
          ph = (ph == 2) ? 0 : ph + 1;
          m_ready = (rdy_mode == 1) || (rdy_mode == 2 && ph == 0);
        end
      end
      begin : monitor
        int occ_m = 0;
        int inf_m = 0;
        bit stall_prev = 0;
        logic [DW-1:0] prev_data = '0;
        exp_t e;
        forever begin
          @(negedge clk);
          if (!rst) begin
            occ_m = 0;
            inf_m = 0;
            stall_prev = 0;
          end else begin
            chk(m_valid == (occ_m != 0), "valid_vs_model", 32'(m_valid), 32'(occ_m != 0));
            if (stall_prev)
              chk(m_valid && m_data == prev_data, "hold_stable", m_data, prev_data);
            if (fifo_rd_en) begin
              chk(occ_m + inf_m < 2, "rd_credit", 32'(occ_m + inf_m), 1);
              chk(!fifo_empty, "rd_on_empty", 32'(fifo_empty), 0);
            end
            if (m_valid && m_ready) begin
              if (exp_q.size() == 0) begin
                chk(1'b0, "extra_beat", m_data, 0);
              end else begin
                e = exp_q.pop_front();
                chk(m_data == e.d, "beat_data", m_data, e.d);
                chk(m_last == e.l, "beat_last", 32'(m_last), 32'(e.l));
                $display("beat data=0x%0h last=%0b", m_data, m_last);
              end
            end
            if (done) done_cnt++;
            stall_prev = m_valid && !m_ready;
            prev_data = m_data;
            occ_m = occ_m + inf_m - ((m_valid && m_ready) ? 1 : 0);
            inf_m = fifo_rd_en ? 1 : 0;
          end
        end
      end
    join_none

    // Reset state
    tick();
    chk(busy == 0, "rst_busy", 32'(busy), 0);
    chk(done == 0, "rst_done", 32'(done), 0);
    chk(fifo_rd_en == 0, "rst_rd_en", 32'(fifo_rd_en), 0);
    chk(m_valid == 0, "rst_valid", 32'(m_valid), 0);
    chk(m_last == 0, "rst_last", 32'(m_last), 0);
    chk(m_data == 0, "rst_data", m_data, 0);
    tick();
    rst = 1'b1;
    tick();

    // T1 basic
    rdy_mode = 1;
    preload(8, 32'h01);
    base = pops;
    run_job(8, 32'h01);
    chk(m_valid == 0, "t1_valid_c0", 32'(m_valid), 0);
    tick();
    chk(m_valid == 0, "t1_valid_c1", 32'(m_valid), 0);
    tick();
    chk(m_valid == 1, "t1_first_valid", 32'(m_valid), 1);
    chk(busy == 1, "t1_busy", 32'(busy), 1);
    wait_done("t1", 200);
    chk(pops - base == 8, "t1_pops", 32'(pops - base), 8);

    // T2 backpressure
    rdy_mode = 2;
    preload(6, 32'h20);
    base = pops;
    run_job(6, 32'h20);
    wait_done("t2", 300);
    chk(pops - base == 6, "t2_pops", 32'(pops - base), 6);

    // T3 underrun: words trickle in one every three cycles
    rdy_mode = 1;
    base = pops;
    run_job(4, 32'h30);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          tick();
          tick();
          push_en = 1'b1;
          push_word = 32'h30 + DW'(i);
          tick();
          push_en = 1'b0;
        end
      end
      wait_done("t3", 300);
    join
    chk(pops - base == 4, "t3_pops", 32'(pops - base), 4);

    // T4 over-full FIFO
    preload(10, 32'h40);
    base = pops;
    run_job(3, 32'h40);
    wait_done("t4", 200);
    chk(pops - base == 3, "t4_pops", 32'(pops - base), 3);
    chk(fifo_q.size() == 7, "t4_left", 32'(fifo_q.size()), 7);
    flush_fifo();

    // T5 zero length, then start during RUN
    base = pops;
    job_len = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk(done == 1, "t5_zero_done", 32'(done), 1);
    chk(busy == 0, "t5_zero_busy", 32'(busy), 0);
    tick();
    chk(done == 0, "t5_zero_pulse", 32'(done), 0);
    chk(pops == base, "t5_zero_pops", 32'(pops - base), 0);
    rdy_mode = 2;
    preload(5, 32'h50);
    base = pops;
    run_job(3, 32'h50);
    tick();
    job_len = LW'(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5", 200);
    chk(pops - base == 3, "t5_pops", 32'(pops - base), 3);
    chk(fifo_q.size() == 2, "t5_left", 32'(fifo_q.size()), 2);
    for (int i = 0; i < 4; i++) tick();
    chk(busy == 0, "t5_no_restart", 32'(busy), 0);
    flush_fifo();

    // T6 reset mid-job with a word sitting in the skid buffer
    rdy_mode = 0;
    preload(4, 32'h60);
    run_job(4, 32'h60);
    begin
      int n = 0;
      while (!m_valid && n < 20) begin
        tick();
        n++;
      end
      chk(m_valid == 1, "t6_valid_before_rst", 32'(m_valid), 1);
    end
    rst = 1'b0;
    #1;
    chk(busy == 0, "t6_busy", 32'(busy), 0);
    chk(m_valid == 0, "t6_valid", 32'(m_valid), 0);
    chk(m_data == 0, "t6_data", m_data, 0);
    chk(fifo_rd_en == 0, "t6_rd_en", 32'(fifo_rd_en), 0);
    chk(m_last == 0, "t6_last", 32'(m_last), 0);
    exp_q.delete();
    flush_fifo();
    rst = 1'b1;
    tick();
    rdy_mode = 1;
    preload(2, 32'h70);
    base = pops;
    run_job(2, 32'h70);
    wait_done("t6", 200);
    chk(pops - base == 2, "t6_pops", 32'(pops - base), 2);

    tick();
    chk(done_cnt == 7, "done_count", 32'(done_cnt), 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
